// File: rtl/dma_write_packer.sv
`default_nettype none
// ============================================================================
// Module   : dma_write_packer
// Purpose  : Packs a valid/ready byte stream MSB-first into 32-bit words and
//            issues one DMA write per word, starting at the programmed word
//            address and decrementing the address after each accepted write.
// Options  : DMA_WRITER_CHECKSUM_EN - build the running 8-bit byte checksum;
//            when undefined o_checksum is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module dma_write_packer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] i_RCC_DMA_ADDR_HIGH,
  input  logic [15:0] i_RCC_DMA_ADDR_LOW,
  input  logic [5:0]  i_RCC_BUFFER_LENGTH,
  input  logic        i_WriterStart,
  input  logic [7:0]  i_byte_in,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        DMA_WRITE,
  output logic [31:0] DMA_WRITE_addr,
  output logic [31:0] DMA_WRITE_data,
  input  logic        i_DMA_WRITE_ack,
  output logic        o_Writer_Done,
  output logic        o_busy,
  output logic        o_start_error,
  output logic [7:0]  o_checksum
);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_PACK  = 2'd1;
  localparam logic [1:0] W_WRITE = 2'd2;
  localparam logic [1:0] W_DONE  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [5:0]  r_len;
  logic [5:0]  r_bytes_cnt;
  logic [1:0]  r_pack_cnt;
  logic        r_start_error;

  logic w_start;
  logic w_accept;
  logic w_word_full;
  logic w_ack;

  // Handshake qualifiers; start and ack are only honoured in their own state
  assign w_start     = i_WriterStart && (r_state == W_IDLE);
  assign w_accept    = i_byte_valid && (r_state == W_PACK);
  // A word closes on its 4th byte or on the last byte of the transfer
  assign w_word_full = w_accept &&
                       ((r_pack_cnt == 2'd3) ||
                        (({1'b0, r_bytes_cnt} + 7'd1) == {1'b0, r_len}));
  assign w_ack       = i_DMA_WRITE_ack && (r_state == W_WRITE);

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= W_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      W_IDLE:  if (i_WriterStart)
                 w_next_state = (i_RCC_BUFFER_LENGTH == 6'd0) ? W_DONE : W_PACK;
      W_PACK:  if (w_word_full) w_next_state = W_WRITE;
      W_WRITE: if (i_DMA_WRITE_ack)
                 w_next_state = (r_bytes_cnt == r_len) ? W_DONE : W_PACK;
      W_DONE:  w_next_state = W_IDLE;
      default: w_next_state = W_IDLE;
    endcase
  end

  // State-decoded outputs; all fall to zero as soon as reset forces W_IDLE
  always_comb begin
    o_byte_ready  = (r_state == W_PACK);
    DMA_WRITE     = (r_state == W_WRITE);
    o_Writer_Done = (r_state == W_DONE);
    o_busy        = (r_state != W_IDLE);
  end

  // Address, length, byte packing and counters
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_addr      <= 32'd0;
      r_data      <= 32'd0;
      r_len       <= 6'd0;
      r_bytes_cnt <= 6'd0;
      r_pack_cnt  <= 2'd0;
    end else if (w_start) begin
      r_addr      <= {i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW};
      r_data      <= 32'd0;
      r_len       <= i_RCC_BUFFER_LENGTH;
      r_bytes_cnt <= 6'd0;
      r_pack_cnt  <= 2'd0;
    end else if (w_accept) begin
      case (r_pack_cnt)
        2'd0:    r_data[31:24] <= i_byte_in;
        2'd1:    r_data[23:16] <= i_byte_in;
        2'd2:    r_data[15:8]  <= i_byte_in;
        default: r_data[7:0]   <= i_byte_in;
      endcase
      r_bytes_cnt <= r_bytes_cnt + 6'd1;
      r_pack_cnt  <= r_pack_cnt + 2'd1;
    end else if (w_ack) begin
      // Wraps modulo 2^32 when decrementing from zero
      r_addr     <= r_addr - 32'd1;
      r_data     <= 32'd0;
      r_pack_cnt <= 2'd0;
    end
  end

  // Sticky flag for start pulses that arrive while a transfer is running
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                     r_start_error <= 1'b0;
    else if (w_start)                              r_start_error <= 1'b0;
    else if (i_WriterStart && (r_state != W_IDLE)) r_start_error <= 1'b1;
  end

  assign DMA_WRITE_addr = r_addr;
  assign DMA_WRITE_data = r_data;
  assign o_start_error  = r_start_error;

`ifdef DMA_WRITER_CHECKSUM_EN
  logic [7:0] r_checksum;

  // Modulo-256 sum of accepted bytes, held after completion until next start
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)         r_checksum <= 8'd0;
    else if (w_start)  r_checksum <= 8'd0;
    else if (w_accept) r_checksum <= r_checksum + i_byte_in;
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_write_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_write_packer
// Purpose  : Self-checking bench for dma_write_packer. Expected words,
//            addresses, handshake levels and checksum come from a simple
//            transfer model (byte list, word index, pending-write flag).
// Options  : honours DMA_WRITER_CHECKSUM_EN for the expected checksum.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_write_packer;

  logic        CLK;
  logic        RESET;
  logic [15:0] i_RCC_DMA_ADDR_HIGH;
  logic [15:0] i_RCC_DMA_ADDR_LOW;
  logic [5:0]  i_RCC_BUFFER_LENGTH;
  logic        i_WriterStart;
  logic [7:0]  i_byte_in;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic        DMA_WRITE;
  logic [31:0] DMA_WRITE_addr;
  logic [31:0] DMA_WRITE_data;
  logic        i_DMA_WRITE_ack;
  logic        o_Writer_Done;
  logic        o_busy;
  logic        o_start_error;
  logic [7:0]  o_checksum;

  int         n_asserts;
  int         n_fails;
  logic [7:0] tx_bytes [64];

  dma_write_packer dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .i_RCC_DMA_ADDR_HIGH (i_RCC_DMA_ADDR_HIGH),
    .i_RCC_DMA_ADDR_LOW  (i_RCC_DMA_ADDR_LOW),
    .i_RCC_BUFFER_LENGTH (i_RCC_BUFFER_LENGTH),
    .i_WriterStart       (i_WriterStart),
    .i_byte_in           (i_byte_in),
    .i_byte_valid        (i_byte_valid),
    .o_byte_ready        (o_byte_ready),
    .DMA_WRITE           (DMA_WRITE),
    .DMA_WRITE_addr      (DMA_WRITE_addr),
    .DMA_WRITE_data      (DMA_WRITE_data),
    .i_DMA_WRITE_ack     (i_DMA_WRITE_ack),
    .o_Writer_Done       (o_Writer_Done),
    .o_busy              (o_busy),
    .o_start_error       (o_start_error),
    .o_checksum          (o_checksum)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_checksum(input int len);
    logic [7:0] s;
    s = 8'd0;
`ifdef DMA_WRITER_CHECKSUM_EN
    for (int i = 0; i < len; i++) s = s + tx_bytes[i];
`endif
    return s;
  endfunction

  // Runs one transfer from a negedge and returns at a negedge with the DUT idle.
  // delay: cycles the ack is withheld per request; inject_at: cycle index for a
  // stray start pulse during packing (-1 for none).
  task automatic run_transfer(input logic [31:0] base, input int len, input int delay,
                              input int valid_pct, input int inject_at);
    int         bi, wi, cnt, nwr;
    logic       pending, d_exp, serr, finished, v;
    logic [31:0] exp_word;
    logic [7:0] csum;
    nwr  = (len + 3) / 4;
    csum = exp_checksum(len);
    i_RCC_DMA_ADDR_HIGH = base[31:16];
    i_RCC_DMA_ADDR_LOW  = base[15:0];
    i_RCC_BUFFER_LENGTH = 6'(len);
    i_WriterStart       = 1'b1;
    i_byte_valid        = 1'b0;
    i_DMA_WRITE_ack     = 1'b0;
    @(posedge CLK); @(negedge CLK);
    i_WriterStart = 1'b0;
    bi = 0; wi = 0; cnt = 0;
    pending = 1'b0; d_exp = (len == 0); serr = 1'b0; finished = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      check("dma_write", 32'(DMA_WRITE), 32'(pending));
      check("byte_ready", 32'(o_byte_ready), 32'(!pending && !d_exp && bi < len));
      check("writer_done", 32'(o_Writer_Done), 32'(d_exp));
      check("busy", 32'(o_busy), 32'd1);
      check("start_error", 32'(o_start_error), 32'(serr));
      check("addr", DMA_WRITE_addr, base - 32'(wi));
      if (d_exp) begin
        check("checksum_done", 32'(o_checksum), 32'(csum));
        finished = 1'b1;
        break;
      end
      i_WriterStart = (cyc == inject_at) && !pending;
      if (i_WriterStart) serr = 1'b1;
      if (pending) begin
        exp_word = 32'd0;
        for (int k = 0; k < 4; k++)
          if (wi * 4 + k < len) exp_word[31 - 8 * k -: 8] = tx_bytes[wi * 4 + k];
        check("write_data", DMA_WRITE_data, exp_word);
        i_byte_valid = 1'($urandom_range(0, 1));
        i_byte_in    = 8'($urandom);
        if (cnt < delay) begin
          i_DMA_WRITE_ack = 1'b0;
          cnt++;
        end else begin
          i_DMA_WRITE_ack = 1'b1;
          cnt = 0;
          pending = 1'b0;
          wi++;
          if (bi == len) d_exp = 1'b1;
        end
      end else begin
        // A stray ack while no request is open must be ignored
        i_DMA_WRITE_ack = 1'($urandom_range(0, 1));
        v = ($urandom_range(1, 100) <= valid_pct);
        i_byte_valid = v;
        i_byte_in    = v ? tx_bytes[bi] : 8'($urandom);
        if (v) begin
          bi++;
          if ((bi % 4 == 0) || (bi == len)) pending = 1'b1;
        end
      end
      @(posedge CLK); @(negedge CLK);
    end
    check("transfer_completed", 32'(finished), 32'd1);
    check("write_count", 32'(wi), 32'(nwr));
    i_WriterStart   = 1'b0;
    i_byte_valid    = 1'b0;
    i_DMA_WRITE_ack = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_done", 32'(o_Writer_Done), 32'd0);
    check("idle_addr", DMA_WRITE_addr, base - 32'(nwr));
    check("checksum_hold", 32'(o_checksum), 32'(csum));
  endtask

  initial begin
    int ok;
    n_asserts = 0;
    n_fails   = 0;
    RESET = 1'b1;
    i_RCC_DMA_ADDR_HIGH = 16'd0;
    i_RCC_DMA_ADDR_LOW  = 16'd0;
    i_RCC_BUFFER_LENGTH = 6'd0;
    i_WriterStart   = 1'b0;
    i_byte_in       = 8'd0;
    i_byte_valid    = 1'b0;
    i_DMA_WRITE_ack = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_dma_write", 32'(DMA_WRITE), 32'd0);
    check("rst_addr", DMA_WRITE_addr, 32'd0);
    check("rst_data", DMA_WRITE_data, 32'd0);
    check("rst_ready", 32'(o_byte_ready), 32'd0);
    check("rst_done", 32'(o_Writer_Done), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_start_error", 32'(o_start_error), 32'd0);
    check("rst_checksum", 32'(o_checksum), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Base 0x10, length 8, bytes 0x01..0x08, back-to-back
    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'(i + 1);
    run_transfer(32'h0000_0010, 8, 0, 100, -1);

    // Partial final word, length 5
    for (int i = 0; i < 5; i++) tx_bytes[i] = 8'(8'hA1 + i);
    run_transfer(32'h1234_5678, 5, 0, 100, -1);

    // Zero length: immediate completion, no writes
    run_transfer(32'h0000_0040, 0, 0, 100, -1);

    // Base 0, delayed ack: address wraps to 0xFFFF_FFFF
    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'($urandom);
    run_transfer(32'h0000_0000, 8, 3, 100, -1);

    // Stray start while packing sets the sticky error
    for (int i = 0; i < 12; i++) tx_bytes[i] = 8'($urandom);
    run_transfer(32'h8000_0100, 12, 1, 70, 2);
    check("start_error_sticky", 32'(o_start_error), 32'd1);

    // Reset while a write request is open
    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'($urandom);
    i_RCC_DMA_ADDR_HIGH = 16'h00AB;
    i_RCC_DMA_ADDR_LOW  = 16'hCDEF;
    i_RCC_BUFFER_LENGTH = 6'd8;
    i_WriterStart = 1'b1;
    @(posedge CLK); @(negedge CLK);
    i_WriterStart = 1'b0;
    i_byte_valid  = 1'b1;
    ok = 0;
    for (int c = 0; c < 20 && ok == 0; c++) begin
      i_byte_in = tx_bytes[c % 8];
      @(posedge CLK); @(negedge CLK);
      if (DMA_WRITE) ok = 1;
    end
    check("reach_write_state", 32'(ok), 32'd1);
    i_byte_valid = 1'b0;
    #2 RESET = 1'b1;
    #1;
    check("async_rst_dma_write", 32'(DMA_WRITE), 32'd0);
    check("async_rst_addr", DMA_WRITE_addr, 32'd0);
    check("async_rst_data", DMA_WRITE_data, 32'd0);
    check("async_rst_ready", 32'(o_byte_ready), 32'd0);
    check("async_rst_busy", 32'(o_busy), 32'd0);
    check("async_rst_done", 32'(o_Writer_Done), 32'd0);
    check("async_rst_start_error", 32'(o_start_error), 32'd0);
    check("async_rst_checksum", 32'(o_checksum), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 4; i++) tx_bytes[i] = 8'($urandom);
    run_transfer(32'h0000_2000, 4, 0, 100, -1);

    // Randomized transfers
    for (int t = 0; t < 6; t++) begin
      int len;
      len = int'($urandom_range(0, 63));
      for (int i = 0; i < 64; i++) tx_bytes[i] = 8'($urandom);
      run_transfer(32'($urandom), len, int'($urandom_range(0, 3)),
                   int'($urandom_range(40, 100)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
